// File: rtl/ahb_slave_arbiter_pkg.sv
// Shared AHB definitions: default master count, htrans encodings and arbiter state type.
package AhbGlobalPackage;

    localparam int AHB_NO_OF_MASTERS = 4;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_OWNED  = 2'd1,
        ARB_LOCKED = 2'd2
    } arb_state_t;

endpackage

// File: rtl/ahb_slave_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module ahb_rr_picker #(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx
);

    logic         found;
    logic [W-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = W'((int'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found       = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_slave_arbiter.sv
// Per-slave AHB arbiter: round-robin with lock precedence, burst retention and locked sequences.
// State table: ARB_IDLE | no owner ; ARB_OWNED | owner holds while BUSY/SEQ ; ARB_LOCKED | owner holds while hmastlock
module ahb_slave_arbiter
    import AhbGlobalPackage::*;
#(
    parameter int NO_OF_MASTERS = AHB_NO_OF_MASTERS,
    localparam int MID_W = $clog2(NO_OF_MASTERS)
) (
    input  logic                       hclk,
    input  logic                       hreset,
    input  logic [NO_OF_MASTERS-1:0]   hreq,
    input  logic [2*NO_OF_MASTERS-1:0] htrans_m,
    input  logic [NO_OF_MASTERS-1:0]   hmastlock_m,
    input  logic                       hready,
    output logic [NO_OF_MASTERS-1:0]   hgrant,
    output logic [MID_W-1:0]           hmaster,
    output logic [MID_W-1:0]           hmaster_data,
    output logic                       data_valid,
    output logic                       arb_locked
);

    arb_state_t               state_q, state_d;
    logic [NO_OF_MASTERS-1:0] hgrant_q, hgrant_d;
    logic [MID_W-1:0]         hmaster_q, hmaster_d;
    logic [MID_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [MID_W-1:0]         hmaster_data_q, hmaster_data_d;
    logic                     data_valid_q, data_valid_d;

    logic [1:0]               owner_trans;
    logic                     owner_lock;
    logic                     rearb;
    logic [NO_OF_MASTERS-1:0] lock_req, lock_onehot, all_onehot, win_onehot;
    logic [MID_W-1:0]         lock_idx, all_idx, win_idx;

    assign owner_trans = htrans_m[{hmaster_q, 1'b0} +: 2];
    assign owner_lock  = hmastlock_m[hmaster_q];
    assign lock_req    = hreq & hmastlock_m;

    ahb_rr_picker #(.N(NO_OF_MASTERS)) u_pick_lock (
        .req   (lock_req),
        .ptr   (rr_ptr_q),
        .grant (lock_onehot),
        .idx   (lock_idx)
    );

    ahb_rr_picker #(.N(NO_OF_MASTERS)) u_pick_all (
        .req   (hreq),
        .ptr   (rr_ptr_q),
        .grant (all_onehot),
        .idx   (all_idx)
    );

    // Locked requesters pre-empt the plain round-robin.
    assign win_onehot = (|lock_req) ? lock_onehot : all_onehot;
    assign win_idx    = (|lock_req) ? lock_idx    : all_idx;

    always_comb begin
        state_d        = state_q;
        hgrant_d       = hgrant_q;
        hmaster_d      = hmaster_q;
        rr_ptr_d       = rr_ptr_q;
        hmaster_data_d = hmaster_data_q;
        data_valid_d   = data_valid_q;
        rearb          = 1'b0;
        if (hready) begin
            hmaster_data_d = hmaster_q;
            data_valid_d   = (|hgrant_q) &&
                             ((owner_trans == HTRANS_NONSEQ) || (owner_trans == HTRANS_SEQ));
            case (state_q)
                ARB_OWNED:  rearb = (owner_trans == HTRANS_NONSEQ) || (owner_trans == HTRANS_IDLE);
                ARB_LOCKED: rearb = !owner_lock;
                default:    rearb = 1'b1;
            endcase
            if (rearb) begin
                if (|hreq) begin
                    hgrant_d  = win_onehot;
                    hmaster_d = win_idx;
                    rr_ptr_d  = (win_idx == MID_W'(NO_OF_MASTERS - 1)) ? '0 : win_idx + 1'b1;
                    state_d   = hmastlock_m[win_idx] ? ARB_LOCKED : ARB_OWNED;
                end else begin
                    hgrant_d = '0;
                    state_d  = ARB_IDLE;
                end
            end
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q        <= ARB_IDLE;
            hgrant_q       <= '0;
            hmaster_q      <= '0;
            rr_ptr_q       <= '0;
            hmaster_data_q <= '0;
            data_valid_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            hgrant_q       <= hgrant_d;
            hmaster_q      <= hmaster_d;
            rr_ptr_q       <= rr_ptr_d;
            hmaster_data_q <= hmaster_data_d;
            data_valid_q   <= data_valid_d;
        end
    end

    assign hgrant       = hgrant_q;
    assign hmaster      = hmaster_q;
    assign hmaster_data = hmaster_data_q;
    assign data_valid   = data_valid_q;
    assign arb_locked   = (state_q == ARB_LOCKED);

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Directed scoreboard bench for ahb_slave_arbiter with four masters.
module tb_ahb_slave_arbiter;

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_BUSY = 2'b01;
    localparam logic [1:0] T_NSEQ = 2'b10;
    localparam logic [1:0] T_SEQ  = 2'b11;

    logic       hclk;
    logic       hreset;
    logic [3:0] hreq;
    logic [7:0] htrans_m;
    logic [3:0] hmastlock_m;
    logic       hready;
    logic [3:0] hgrant;
    logic [1:0] hmaster;
    logic [1:0] hmaster_data;
    logic       data_valid;
    logic       arb_locked;

    typedef struct {
        string      tag;
        logic [3:0] g;
        logic [1:0] m;
        logic [1:0] md;
        logic       dv;
        logic       lk;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    ahb_slave_arbiter dut (
        .hclk         (hclk),
        .hreset       (hreset),
        .hreq         (hreq),
        .htrans_m     (htrans_m),
        .hmastlock_m  (hmastlock_m),
        .hready       (hready),
        .hgrant       (hgrant),
        .hmaster      (hmaster),
        .hmaster_data (hmaster_data),
        .data_valid   (data_valid),
        .arb_locked   (arb_locked)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_m(input int m, input logic [1:0] t, input logic l);
        htrans_m[2*m +: 2] = t;
        hreq[m]            = (t != T_IDLE);
        hmastlock_m[m]     = l;
    endtask

    task automatic drive(input logic [1:0] t0, t1, t2, t3, input logic [3:0] lk);
        set_m(0, t0, lk[0]);
        set_m(1, t1, lk[1]);
        set_m(2, t2, lk[2]);
        set_m(3, t3, lk[3]);
    endtask

    task automatic push(input string tag, input logic [3:0] g, input logic [1:0] m,
                        input logic [1:0] md, input logic dv, input logic lk);
        exp_t e;
        e.tag = tag; e.g = g; e.m = m; e.md = md; e.dv = dv; e.lk = lk;
        sb.push_back(e);
    endtask

    task automatic check_now(input string tag, input logic [3:0] g, input logic [1:0] m,
                             input logic [1:0] md, input logic dv, input logic lk);
        chk({tag, ".hgrant"},       32'(hgrant),       32'(g));
        chk({tag, ".hmaster"},      32'(hmaster),      32'(m));
        chk({tag, ".hmaster_data"}, 32'(hmaster_data), 32'(md));
        chk({tag, ".data_valid"},   32'(data_valid),   32'(dv));
        chk({tag, ".arb_locked"},   32'(arb_locked),   32'(lk));
    endtask

    task automatic tick();
        exp_t e;
        @(posedge hclk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty at time %0t", $time);
        end else begin
            e = sb.pop_front();
            check_now(e.tag, e.g, e.m, e.md, e.dv, e.lk);
        end
    endtask

    task automatic step(input string tag, input logic [3:0] g, input logic [1:0] m,
                        input logic [1:0] md, input logic dv, input logic lk);
        push(tag, g, m, md, dv, lk);
        tick();
    endtask

    initial begin
        hreset = 1'b0; hready = 1'b1;
        hreq = '0; htrans_m = '0; hmastlock_m = '0;
        #1 hreset = 1'b1;
        #1 check_now("reset", 4'b0000, 2'd0, 2'd0, 1'b0, 1'b0);
        @(posedge hclk);
        #2 hreset = 1'b0;

        // Two requesters from rr_ptr=0, then re-arbitration rotates to master 2.
        drive(T_IDLE, T_NSEQ, T_NSEQ, T_IDLE, 4'b0000);
        step("rr_first",  4'b0010, 2'd1, 2'd0, 1'b0, 1'b0);
        step("rr_second", 4'b0100, 2'd2, 2'd1, 1'b1, 1'b0);
        drive(T_IDLE, T_IDLE, T_IDLE, T_IDLE, 4'b0000);
        step("to_idle",   4'b0000, 2'd2, 2'd2, 1'b0, 1'b0);
        step("idle_hold", 4'b0000, 2'd2, 2'd2, 1'b0, 1'b0);

        // Fresh reset, then locked master 3 beats master 1 at rr_ptr=0.
        #2 hreset = 1'b1;
        #1 check_now("reset2", 4'b0000, 2'd0, 2'd0, 1'b0, 1'b0);
        #2 hreset = 1'b0;
        drive(T_IDLE, T_NSEQ, T_IDLE, T_NSEQ, 4'b1000);
        step("lock_prec",   4'b1000, 2'd3, 2'd0, 1'b0, 1'b1);
        drive(T_IDLE, T_NSEQ, T_IDLE, T_SEQ, 4'b1000);
        step("lock_hold",   4'b1000, 2'd3, 2'd3, 1'b1, 1'b1);

        // Master 0 wins after wrap and keeps an INCR4 burst (with one BUSY) against all requesters.
        drive(T_NSEQ, T_NSEQ, T_NSEQ, T_NSEQ, 4'b0000);
        step("burst_nseq",  4'b0001, 2'd0, 2'd3, 1'b1, 1'b0);
        drive(T_SEQ, T_NSEQ, T_NSEQ, T_NSEQ, 4'b0000);
        step("burst_seq1",  4'b0001, 2'd0, 2'd0, 1'b1, 1'b0);
        drive(T_BUSY, T_NSEQ, T_NSEQ, T_NSEQ, 4'b0000);
        step("burst_busy",  4'b0001, 2'd0, 2'd0, 1'b0, 1'b0);
        drive(T_SEQ, T_NSEQ, T_NSEQ, T_NSEQ, 4'b0000);
        step("burst_seq2",  4'b0001, 2'd0, 2'd0, 1'b1, 1'b0);
        step("burst_seq3",  4'b0001, 2'd0, 2'd0, 1'b1, 1'b0);
        drive(T_IDLE, T_NSEQ, T_NSEQ, T_NSEQ, 4'b0000);
        step("burst_end",   4'b0010, 2'd1, 2'd0, 1'b0, 1'b0);

        // Wait states freeze everything while master 3 requests.
        drive(T_IDLE, T_NSEQ, T_IDLE, T_NSEQ, 4'b0000);
        hready = 1'b0;
        step("stall1", 4'b0010, 2'd1, 2'd0, 1'b0, 1'b0);
        step("stall2", 4'b0010, 2'd1, 2'd0, 1'b0, 1'b0);
        step("stall3", 4'b0010, 2'd1, 2'd0, 1'b0, 1'b0);
        hready = 1'b1;
        step("stall_release", 4'b1000, 2'd3, 2'd1, 1'b1, 1'b0);

        // Locked master 2 holds off everyone until it drops hmastlock, then master 3 with no gap.
        drive(T_NSEQ, T_NSEQ, T_NSEQ, T_NSEQ, 4'b0100);
        step("lk2_grant", 4'b0100, 2'd2, 2'd3, 1'b1, 1'b1);
        drive(T_NSEQ, T_NSEQ, T_SEQ, T_NSEQ, 4'b0100);
        step("lk2_seq",   4'b0100, 2'd2, 2'd2, 1'b1, 1'b1);
        drive(T_NSEQ, T_NSEQ, T_IDLE, T_NSEQ, 4'b0100);
        step("lk2_idle",  4'b0100, 2'd2, 2'd2, 1'b0, 1'b1);
        drive(T_NSEQ, T_NSEQ, T_NSEQ, T_NSEQ, 4'b0100);
        step("lk2_nseq",  4'b0100, 2'd2, 2'd2, 1'b1, 1'b1);
        drive(T_NSEQ, T_NSEQ, T_NSEQ, T_NSEQ, 4'b0000);
        step("lk2_drop",  4'b1000, 2'd3, 2'd2, 1'b1, 1'b0);

        // Master 1 mid-burst, asynchronous reset, then fresh arbitration grants master 0.
        drive(T_IDLE, T_NSEQ, T_IDLE, T_IDLE, 4'b0000);
        step("m1_grant",  4'b0010, 2'd1, 2'd3, 1'b0, 1'b0);
        drive(T_IDLE, T_SEQ, T_IDLE, T_IDLE, 4'b0000);
        step("m1_seq",    4'b0010, 2'd1, 2'd1, 1'b1, 1'b0);
        #2 hreset = 1'b1;
        #1 check_now("reset_mid", 4'b0000, 2'd0, 2'd0, 1'b0, 1'b0);
        drive(T_NSEQ, T_SEQ, T_IDLE, T_IDLE, 4'b0000);
        #2 hreset = 1'b0;
        step("post_reset", 4'b0001, 2'd0, 2'd0, 1'b0, 1'b0);
        drive(T_IDLE, T_NSEQ, T_IDLE, T_IDLE, 4'b0000);
        step("post_reset2", 4'b0010, 2'd1, 2'd0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
